// File: rtl/ddr3_read_phase_trainer.sv
// DDR3 read-clock phase trainer: sweeps eight clock phases, runs read-compare
// tests at each one, then steps the clock back to the centre of the widest passing window.
module ddr3_read_phase_trainer #(
    parameter int STEP_HOLD       = 4,
    parameter int SETTLE_CYCLES   = 64,
    parameter int TESTS_PER_PHASE = 4,
    parameter int TIMEOUT         = 1024
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic       pll_locked,
    input  logic       test_done,
    input  logic       test_pass,
    output logic       test_req,
    output logic       phase_step,
    output logic       phase_updn,
    output logic [2:0] cur_phase,
    output logic [7:0] pass_map,
    output logic [2:0] best_phase,
    output logic       busy,
    output logic       done,
    output logic       fail,
    output logic [1:0] err
);

    localparam int CW = $clog2(TIMEOUT + SETTLE_CYCLES + STEP_HOLD + 1);
    localparam int PW = $clog2(TESTS_PER_PHASE + 1);

    typedef enum logic [3:0] {
        IDLE, WAIT_LOCK, TEST_REQ, TEST_WAIT, STEP_SETUP, STEP_HI,
        STEP_LO, SETTLE, EVAL, MOVE, DONE, FAIL
    } state_t;

    state_t      state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [PW-1:0] pcnt_q, pcnt_d;
    logic [3:0]  nphase_q, nphase_d;
    logic        move_q, move_d;
    logic        start_q;
    logic        test_req_q, test_req_d;
    logic        phase_step_q, phase_step_d;
    logic        phase_updn_q, phase_updn_d;
    logic [2:0]  cur_phase_q, cur_phase_d;
    logic [7:0]  pass_map_q, pass_map_d;
    logic [2:0]  best_phase_q, best_phase_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        fail_q, fail_d;
    logic [1:0]  err_q, err_d;
    logic        lock_lost;

    // Centre of the longest circular run of ones; ties keep the lowest start.
    function automatic logic [2:0] pick_best(input logic [7:0] m);
        logic [3:0] best_len;
        logic [3:0] len;
        logic [2:0] best_start;
        logic [2:0] idx;
        logic       run;
        best_len   = 4'd0;
        best_start = 3'd0;
        for (int s = 0; s < 8; s++) begin
            len = 4'd0;
            run = 1'b1;
            for (int k = 0; k < 8; k++) begin
                idx = 3'(s + k);
                if (run && m[idx]) len = len + 4'd1;
                else run = 1'b0;
            end
            if (len > best_len) begin
                best_len   = len;
                best_start = 3'(s);
            end
        end
        return best_start + 3'((best_len - 4'd1) >> 1);
    endfunction

    assign lock_lost = !pll_locked && (state_q inside {TEST_REQ, TEST_WAIT,
        STEP_SETUP, STEP_HI, STEP_LO, SETTLE, EVAL, MOVE});

    // Next-state and next-output computation for the whole trainer.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        pcnt_d       = pcnt_q;
        nphase_d     = nphase_q;
        move_d       = move_q;
        phase_updn_d = phase_updn_q;
        cur_phase_d  = cur_phase_q;
        pass_map_d   = pass_map_q;
        best_phase_d = best_phase_q;
        done_d       = done_q;
        fail_d       = fail_q;
        err_d        = err_q;
        if (lock_lost) begin
            state_d = FAIL;
            fail_d  = 1'b1;
            err_d   = 2'd2;
        end else begin
            unique case (state_q)
                IDLE: begin
                    if (start && !start_q) begin
                        state_d    = WAIT_LOCK;
                        pass_map_d = 8'h00;
                        done_d     = 1'b0;
                        fail_d     = 1'b0;
                        err_d      = 2'd0;
                        nphase_d   = 4'd0;
                        move_d     = 1'b0;
                    end
                end
                WAIT_LOCK: begin
                    if (pll_locked) begin
                        state_d = TEST_REQ;
                        pcnt_d  = '0;
                    end
                end
                TEST_REQ: begin
                    state_d = TEST_WAIT;
                    cnt_d   = CW'(1);
                end
                TEST_WAIT: begin
                    if (test_done) begin
                        if (!test_pass || pcnt_q == PW'(TESTS_PER_PHASE - 1)) begin
                            pass_map_d[cur_phase_q] = test_pass;
                            state_d      = STEP_SETUP;
                            phase_updn_d = 1'b1;
                            nphase_d     = nphase_q + 4'd1;
                        end else begin
                            pcnt_d  = pcnt_q + PW'(1);
                            state_d = TEST_REQ;
                        end
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        err_d   = 2'd3;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STEP_SETUP: begin
                    state_d     = STEP_HI;
                    cnt_d       = '0;
                    cur_phase_d = phase_updn_q ? cur_phase_q + 3'd1
                                               : cur_phase_q - 3'd1;
                end
                STEP_HI: begin
                    if (cnt_q == CW'(STEP_HOLD - 1)) begin
                        state_d = STEP_LO;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                STEP_LO: begin
                    if (cnt_q == CW'(STEP_HOLD - 1)) begin
                        state_d = SETTLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                SETTLE: begin
                    if (cnt_q == CW'(SETTLE_CYCLES - 1)) begin
                        cnt_d = '0;
                        if (move_q) begin
                            state_d = MOVE;
                        end else if (nphase_q == 4'd8) begin
                            state_d = EVAL;
                        end else begin
                            state_d = TEST_REQ;
                            pcnt_d  = '0;
                        end
                    end else begin
                        cnt_d = cnt_q + CW'(1);
                    end
                end
                EVAL: begin
                    if (pass_map_q == 8'h00) begin
                        state_d = FAIL;
                        fail_d  = 1'b1;
                        err_d   = 2'd1;
                    end else begin
                        best_phase_d = pick_best(pass_map_q);
                        move_d       = 1'b1;
                        state_d      = MOVE;
                    end
                end
                MOVE: begin
                    if (cur_phase_q == best_phase_q) begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d      = STEP_SETUP;
                        phase_updn_d = (best_phase_q <= 3'd4);
                    end
                end
                DONE:    state_d = IDLE;
                FAIL:    state_d = IDLE;
                default: state_d = IDLE;
            endcase
        end
        test_req_d   = (state_d == TEST_REQ);
        phase_step_d = (state_d == STEP_HI);
        busy_d       = !(state_d inside {IDLE, DONE, FAIL});
    end

    // State and registered outputs; reset clears everything to zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            cnt_q        <= '0;
            pcnt_q       <= '0;
            nphase_q     <= 4'd0;
            move_q       <= 1'b0;
            start_q      <= 1'b0;
            test_req_q   <= 1'b0;
            phase_step_q <= 1'b0;
            phase_updn_q <= 1'b0;
            cur_phase_q  <= 3'd0;
            pass_map_q   <= 8'h00;
            best_phase_q <= 3'd0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
            err_q        <= 2'd0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            pcnt_q       <= pcnt_d;
            nphase_q     <= nphase_d;
            move_q       <= move_d;
            start_q      <= start;
            test_req_q   <= test_req_d;
            phase_step_q <= phase_step_d;
            phase_updn_q <= phase_updn_d;
            cur_phase_q  <= cur_phase_d;
            pass_map_q   <= pass_map_d;
            best_phase_q <= best_phase_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
            err_q        <= err_d;
        end
    end

    assign test_req   = test_req_q;
    assign phase_step = phase_step_q;
    assign phase_updn = phase_updn_q;
    assign cur_phase  = cur_phase_q;
    assign pass_map   = pass_map_q;
    assign best_phase = best_phase_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign fail       = fail_q;
    assign err        = err_q;

endmodule

// File: tb/tb_ddr3_read_phase_trainer.sv
// Bench for ddr3_read_phase_trainer: emulated clocking block and memory tester,
// per-cycle tracking checks plus directed end-of-run expectations.
module tb_ddr3_read_phase_trainer;

    localparam int SH  = 2;
    localparam int SC  = 5;
    localparam int TPP = 2;
    localparam int TMO = 40;

    logic       clk = 1'b0;
    logic       rst, start, pll_locked, test_done, test_pass;
    logic       test_req, phase_step, phase_updn, busy, done, fail;
    logic [2:0] cur_phase, best_phase;
    logic [7:0] pass_map;
    logic [1:0] err;

    int nchk = 0;
    int npass = 0;
    logic [7:0] pass_pat = 8'h00;
    bit respond_en = 1'b1;
    bit spur_req = 1'b0;
    bit spur_ack = 1'b0;
    int phys = 0, ups = 0, downs = 0, reqs = 0, cyc = 0, last_req_cyc = 0;
    int u0 = 0, d0 = 0, r0 = 0;
    logic prev_step = 1'b0;
    logic updn_rise = 1'b0;

    always #5 clk = ~clk;

    ddr3_read_phase_trainer #(
        .STEP_HOLD(SH), .SETTLE_CYCLES(SC),
        .TESTS_PER_PHASE(TPP), .TIMEOUT(TMO)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .pll_locked(pll_locked),
        .test_done(test_done), .test_pass(test_pass),
        .test_req(test_req), .phase_step(phase_step), .phase_updn(phase_updn),
        .cur_phase(cur_phase), .pass_map(pass_map), .best_phase(best_phase),
        .busy(busy), .done(done), .fail(fail), .err(err)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act === exp) npass++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    function automatic bit bitat(input logic [7:0] m, input int i);
        return m[3'(i % 8)];
    endfunction

    // Centre of the widest circular window, found by walking run starts.
    function automatic int model_best(input logic [7:0] m);
        int bs, bl, l;
        bs = 0;
        bl = 0;
        for (int s = 0; s < 8; s++) begin
            if (bitat(m, s) && !bitat(m, s + 7)) begin
                l = 0;
                while (l < 8 && bitat(m, s + l)) l++;
                if (l > bl) begin bl = l; bs = s; end
            end
        end
        if (m == 8'hFF) begin bs = 0; bl = 8; end
        return (bs + (bl - 1) / 2) % 8;
    endfunction

    // Memory tester: answers each test_req three cycles later.
    initial begin
        int lat;
        lat = -1;
        test_done = 1'b0;
        test_pass = 1'b0;
        forever begin
            @(negedge clk);
            test_done = 1'b0;
            test_pass = 1'b0;
            if (rst) lat = -1;
            if (lat == 0) begin
                test_done = 1'b1;
                test_pass = pass_pat[phys[2:0]];
                lat = -1;
            end else if (lat > 0) begin
                lat--;
            end
            if (test_req === 1'b1 && respond_en) lat = 2;
            if (spur_req != spur_ack) begin
                test_done = 1'b1;
                test_pass = 1'b0;
                spur_ack = spur_req;
            end
        end
    end

    // Clocking-block model and per-cycle checks.
    initial forever begin
        @(negedge clk);
        cyc++;
        if (rst) begin
            phys = 0;
            prev_step = 1'b0;
        end else begin
            if (phase_step && !prev_step) begin
                if (phase_updn) begin phys = (phys + 1) % 8; ups++; end
                else begin phys = (phys + 7) % 8; downs++; end
                updn_rise = phase_updn;
            end
            if (test_req) begin reqs++; last_req_cyc = cyc; end
            chk("cur_phase_track", cur_phase, phys);
            if (phase_step) chk("updn_stable", phase_updn, updn_rise);
            chk("step_needs_busy", phase_step & ~busy, 0);
            chk("status_excl", busy & (done | fail), 0);
            prev_step = phase_step;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin @(negedge clk); #1; end
    endtask

    task automatic chk_zero(input string name);
        chk(name, {test_req, phase_step, phase_updn, cur_phase, pass_map,
                   best_phase, busy, done, fail, err}, 0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        chk_zero("reset_outputs");
    endtask

    task automatic arm(input logic [7:0] pat);
        pass_pat = pat;
        u0 = ups; d0 = downs; r0 = reqs;
        start = 1'b1;
        tick(1);
        start = 1'b0;
        chk("busy_after_start", busy, 1);
    endtask

    task automatic wait_end(input int maxc);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < maxc; i++) begin
            tick(1);
            if (done || fail) begin ok = 1'b1; break; end
        end
        chk("run_ends", ok, 1);
    endtask

    task automatic wait_step(input logic want, input int ph);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < 2000; i++) begin
            tick(1);
            if (phase_step == want && (ph < 0 || int'(cur_phase) == ph)) begin
                ok = 1'b1;
                break;
            end
        end
        chk("step_seen", ok, 1);
    endtask

    task automatic end_run(input logic [7:0] pat, input logic [7:0] lit_map,
                           input int lit_best);
        bit nf;
        int b, pop, eu, ed;
        wait_end(3000);
        nf  = (pat != 8'h00);
        b   = model_best(pat);
        pop = $countones(pat);
        eu  = 8 + ((nf && b <= 4) ? b : 0);
        ed  = (nf && b > 4) ? 8 - b : 0;
        chk("done_flag", done, nf);
        chk("fail_flag", fail, !nf);
        chk("err_code", err, nf ? 0 : 1);
        chk("pass_map_model", pass_map, pat);
        chk("pass_map_lit", pass_map, lit_map);
        chk("up_steps", ups - u0, eu);
        chk("down_steps", downs - d0, ed);
        chk("test_reqs", reqs - r0, pop * TPP + (8 - pop));
        if (nf) begin
            chk("best_model", best_phase, b);
            chk("best_lit", best_phase, lit_best);
            chk("final_phase", phys, lit_best);
        end
        tick(2);
        chk("idle_not_busy", busy, 0);
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        pll_locked = 1'b1;

        pll_locked = 1'b0;
        do_reset();
        arm(8'h1C);
        tick(6);
        chk("wait_lock_no_req", reqs - r0, 0);
        chk("wait_lock_busy", busy, 1);
        pll_locked = 1'b1;
        end_run(8'h1C, 8'h1C, 3);

        do_reset();
        arm(8'hC3);
        wait_step(1'b1, -1);
        start = 1'b1;
        tick(1);
        start = 1'b0;
        end_run(8'hC3, 8'hC3, 7);

        do_reset();
        arm(8'hFF);
        wait_step(1'b1, -1);
        spur_req = ~spur_req;
        end_run(8'hFF, 8'hFF, 3);

        do_reset();
        arm(8'h00);
        end_run(8'h00, 8'h00, 0);

        respond_en = 1'b0;
        do_reset();
        arm(8'hFF);
        wait_end(500);
        chk("tmo_fail", fail, 1);
        chk("tmo_err", err, 3);
        chk("tmo_latency", cyc - last_req_cyc, TMO);
        chk("tmo_one_req", reqs - r0, 1);
        chk("tmo_busy", busy, 0);
        respond_en = 1'b1;

        do_reset();
        arm(8'h1C);
        wait_step(1'b1, 3);
        wait_step(1'b0, -1);
        tick(SH + 1);
        pll_locked = 1'b0;
        tick(1);
        chk("lock_fail", fail, 1);
        chk("lock_err", err, 2);
        chk("lock_step_low", phase_step, 0);
        chk("lock_busy", busy, 0);
        chk("lock_map", pass_map, 8'h04);
        chk("lock_done", done, 0);
        pll_locked = 1'b1;

        do_reset();
        arm(8'h1C);
        wait_step(1'b1, -1);
        rst = 1'b1;
        tick(1);
        chk_zero("rst_mid_step");
        rst = 1'b0;
        tick(1);
        arm(8'h1C);
        end_run(8'h1C, 8'h1C, 3);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
